rr_channel_arbiter: RTL and testbench
=====================================

Name: rr_channel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the M-channel select multiplexer.
- Picks one of CHANNELS_COUNT requesting producers and drives the mux select code plus a one-hot grant.
- Holds the choice stable until the downstream consumer accepts it via a valid/ready handshake.
- Rotating priority guarantees no requester is starved.

Parameters:
- CHANNELS_COUNT, default 5: number of requesters/mux channels; must be >= 2. Elaboration-time fatal otherwise.
- SEL_WIDTH, default $clog2(CHANNELS_COUNT): width of select. Derived; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  CHANNELS_COUNT  per-channel request; bit i = channel i has data.
- out_ready  input  1  downstream accepts the currently selected channel this cycle.
- out_valid  output  1  a grant is active and select is valid.
- select  output  SEL_WIDTH  binary index of granted channel; feeds the mux select input.
- grant  output  CHANNELS_COUNT  one-hot of granted channel; all zero when out_valid=0.

Behaviour:
- Reset (rst_n=0 sampled at rising edge):
  - out_valid=0, grant=0, select=0, state=IDLE.
  - Priority pointer ptr=0, so channel 0 has highest priority first.
  - Reset overrides every other event in the same cycle, including a handshake in progress; the pending grant is dropped with no pointer update.
- All outputs are registered; there is no combinational path from req or out_ready to any output.
- State IDLE:
  - out_valid=0.
  - If req != 0: winner = first set bit searching ptr, ptr+1, …, CHANNELS_COUNT-1, 0, …, ptr-1.
  - Next cycle: out_valid=1, select=winner, grant=1<<winner, state=GRANT.
  - Latency from req assertion to out_valid is 1 cycle.
  - If req == 0: remain in IDLE.
- State GRANT:
  - select and grant are held constant while out_valid=1 && out_ready=0, even if req[select] drops. Requesters must hold data until granted; the grant is sticky.
  - Handshake = out_valid && out_ready. On a handshake:
    - ptr <= select+1, wrapping to 0 when select == CHANNELS_COUNT-1.
    - Back-to-back re-arbitration in the same cycle, using the updated pointer value and current req. The just-served channel has lowest priority.
    - If any req is set: next cycle out_valid=1 with the new winner, which may be the same channel only if it is the sole requester. No bubble.
    - If req == 0: next cycle out_valid=0, grant=0, select keeps its last value, state=IDLE.
- Arithmetic and invariants:
  - The pointer is compared and wrapped modulo CHANNELS_COUNT, not 2^SEL_WIDTH.
  - select is never >= CHANNELS_COUNT for non-power-of-two counts.
  - grant is always one-hot or zero.
  - grant[select]==1 whenever out_valid=1.
- Fairness: with all requests continuously asserted and out_ready=1, grants cycle 0,1,…,N-1,0… with exactly one grant per cycle.
- out_ready while out_valid=0 is ignored; there is no pointer change.
- Assertions required in RTL (simulation only):
  - grant is one-hot-or-zero.
  - select < CHANNELS_COUNT.
  - select is stable while out_valid && !out_ready.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles with req=5'b11111, then release with req=0.
   - Required: out_valid=0, grant=0, select=0 throughout.
2. Single request: N=5, req=5'b00100 from cycle 0, out_ready=1.
   - Required: cycle 1 out_valid=1, select=2, grant=00100.
   - Held req re-grants channel 2 every cycle.
   - Dropping req gives out_valid=0 one cycle after the last handshake.
3. Full rotation: req=5'b11111, out_ready=1.
   - Required: select sequence 0,1,2,3,4,0,1 on consecutive cycles with no bubbles.
4. Backpressure: req=5'b01010, out_ready=0 for 4 cycles, then 1. Drop req[1] during the stall.
   - Required: select=1 stable throughout the stall.
   - After acceptance, select=3, then IDLE.
5. Wrap and skip: complete a handshake on channel 4, then req=5'b00011.
   - Required: next grant is channel 0, then channel 1.
6. Reset mid-grant: out_valid=1 with select=3 and out_ready=0; assert rst_n=0 together with out_ready=1.
   - Required: next cycle out_valid=0, grant=0, select=0.
   - With req=5'b11111 after release, the first grant is channel 0.

Source files
------------

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter driving the select code and one-hot grant of an M-channel mux.
// Grants are sticky until accepted; re-arbitration on a handshake happens with no bubble.
module rr_channel_arbiter #(
  parameter int CHANNELS_COUNT = 5,
  parameter int SEL_WIDTH      = $clog2(CHANNELS_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS_COUNT-1:0] req,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [SEL_WIDTH-1:0]      select,
  output logic [CHANNELS_COUNT-1:0] grant,
  output logic                      o_dbg_state
);

  if (CHANNELS_COUNT < 2) begin : g_bad_param
    $fatal(1, "rr_channel_arbiter: CHANNELS_COUNT must be >= 2");
  end

  // Handshake: a transfer happens on a rising edge where out_valid && out_ready.
  // select/grant hold while out_valid && !out_ready; out_ready is ignored when idle.

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                      r_state;
  logic [SEL_WIDTH-1:0]        r_ptr;
  logic                        r_valid;
  logic [SEL_WIDTH-1:0]        r_select;
  logic [CHANNELS_COUNT-1:0]   r_grant;

  logic                        w_handshake;
  logic [SEL_WIDTH-1:0]        w_ptr_next;
  logic [SEL_WIDTH-1:0]        w_arb_ptr;
  logic [SEL_WIDTH-1:0]        w_winner;
  logic                        w_found;
  int                          w_idx;

  assign w_handshake = (r_state == ST_GRANT) && r_valid && out_ready;
  // Wrap modulo the channel count, not 2^SEL_WIDTH.
  assign w_ptr_next  = (r_select == SEL_WIDTH'(CHANNELS_COUNT - 1)) ? '0 : r_select + 1'b1;
  assign w_arb_ptr   = w_handshake ? w_ptr_next : r_ptr;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < CHANNELS_COUNT; k++) begin
      w_idx = int'(w_arb_ptr) + k;
      if (w_idx >= CHANNELS_COUNT) w_idx = w_idx - CHANNELS_COUNT;
      if (!w_found && req[w_idx[SEL_WIDTH-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[SEL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_select <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_GRANT;
            r_valid  <= 1'b1;
            r_select <= w_winner;
            r_grant  <= {{(CHANNELS_COUNT-1){1'b0}}, 1'b1} << w_winner;
          end
        end
        ST_GRANT: begin
          if (w_handshake) begin
            r_ptr <= w_ptr_next;
            if (w_found) begin
              r_select <= w_winner;
              r_grant  <= {{(CHANNELS_COUNT-1){1'b0}}, 1'b1} << w_winner;
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign select      = r_select;
  assign grant       = r_grant;
  assign o_dbg_state = (r_state == ST_GRANT);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_select_range:  assert property (@(posedge clk) disable iff (!rst_n) int'(select) < CHANNELS_COUNT);
  a_select_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                    (out_valid && !out_ready) |=> $stable(select));
  a_grant_matches: assert property (@(posedge clk) disable iff (!rst_n)
                                    out_valid |-> grant[select]);

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter (5 channels) with hand-computed expectations.
module tb_rr_channel_arbiter;

  localparam int N  = 5;
  localparam int SW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          out_ready;
  logic          out_valid;
  logic [SW-1:0] select;
  logic [N-1:0]  grant;
  logic          dbg_state;

  int n_checks;
  int n_errors;

  rr_channel_arbiter #(.CHANNELS_COUNT(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .select      (select),
    .grant       (grant),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input int s, input logic [N-1:0] g);
    check({tag, ".valid"},  32'(out_valid), 32'(v));
    check({tag, ".select"}, 32'(select),    32'(s));
    check({tag, ".grant"},  32'(grant),     32'(g));
    check({tag, ".state"},  32'(dbg_state), 32'(v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req       = 5'b11111;
    out_ready = 1'b0;

    // 1. reset then idle
    step(); check_out("t1_rst0", 1'b0, 0, 5'b00000);
    step(); check_out("t1_rst1", 1'b0, 0, 5'b00000);
    rst_n = 1'b1; req = 5'b00000;
    step(); check_out("t1_idle0", 1'b0, 0, 5'b00000);
    out_ready = 1'b1;
    step(); check_out("t1_idle1", 1'b0, 0, 5'b00000);

    // 2. single request, held then dropped
    req = 5'b00100;
    step(); check_out("t2_c1", 1'b1, 2, 5'b00100);
    step(); check_out("t2_c2", 1'b1, 2, 5'b00100);
    step(); check_out("t2_c3", 1'b1, 2, 5'b00100);
    req = 5'b00000;
    step(); check_out("t2_drop", 1'b0, 2, 5'b00000);

    // 3. full rotation from ptr=0
    do_reset();
    req = 5'b11111; out_ready = 1'b1;
    begin
      int exp_seq[7] = '{0, 1, 2, 3, 4, 0, 1};
      for (int i = 0; i < 7; i++) begin
        step();
        check_out($sformatf("t3_rot%0d", i), 1'b1, exp_seq[i], 5'(1 << exp_seq[i]));
      end
    end
    req = 5'b00000;
    step(); check_out("t3_idle", 1'b0, 1, 5'b00000);

    // 4. backpressure with req[1] dropped during the stall
    do_reset();
    req = 5'b01010; out_ready = 1'b0;
    step(); check_out("t4_grant", 1'b1, 1, 5'b00010);
    req = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      step(); check_out($sformatf("t4_stall%0d", i), 1'b1, 1, 5'b00010);
    end
    out_ready = 1'b1;
    step(); check_out("t4_next", 1'b1, 3, 5'b01000);
    req = 5'b00000;
    step(); check_out("t4_idle", 1'b0, 3, 5'b00000);

    // 5. wrap from channel 4 and skip to channel 0, then 1
    req = 5'b10000;
    step(); check_out("t5_c4", 1'b1, 4, 5'b10000);
    req = 5'b00011;
    step(); check_out("t5_c0", 1'b1, 0, 5'b00001);
    step(); check_out("t5_c1", 1'b1, 1, 5'b00010);
    step(); check_out("t5_c0b", 1'b1, 0, 5'b00001);
    req = 5'b00000;
    step(); check_out("t5_idle", 1'b0, 0, 5'b00000);
    // ptr is now 1: out_ready while idle must not move it
    step(); check_out("t5_idle2", 1'b0, 0, 5'b00000);

    // 6. reset mid-grant overrides the handshake
    req = 5'b01100; out_ready = 1'b0;
    step(); check_out("t6_grant", 1'b1, 2, 5'b00100);
    req = 5'b01000; out_ready = 1'b1;
    step(); check_out("t6_sel3", 1'b1, 3, 5'b01000);
    out_ready = 1'b0;
    step(); check_out("t6_stall", 1'b1, 3, 5'b01000);
    rst_n = 1'b0; out_ready = 1'b1; req = 5'b11111;
    step(); check_out("t6_rst", 1'b0, 0, 5'b00000);
    rst_n = 1'b1;
    step(); check_out("t6_first", 1'b1, 0, 5'b00001);
    step(); check_out("t6_second", 1'b1, 1, 5'b00010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
